fir_tap_sequencer: RTL

Controller that time-multiplexes one external SB_MAC16-style multiply-accumulate unit across all taps of an FIR filter. It accepts one input sample at a time, holds it in a circular sample buffer and a writable coefficient bank, and issues one coefficient/sample pair per cycle to the MAC. It then captures and saturates the accumulated result and presents one filtered output per accepted sample. It sits between the sample source (ADC/front end) and downstream audio processing, replacing ad-hoc tap counting around the MAC.

---
 rtl/fir_pkg.sv | 25 ++
 rtl/fir_tap_buffer.sv | 58 +++++
 rtl/fir_tap_sequencer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared types, widths and the output saturation helper for the FIR tap sequencer.
package fir_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned COEF_W   = 16;
    localparam int unsigned ACC_W    = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fir_state_t;

    // Clamp a signed accumulator value into the signed 16-bit output range.
    function automatic logic [15:0] sat16(input logic signed [ACC_W-1:0] v);
        if (v > 32'sd32767) begin
            return 16'h7FFF;
        end else if (v < -32'sd32768) begin
            return 16'h8000;
        end else begin
            return v[15:0];
        end
    endfunction

endpackage

// File: rtl/fir_tap_buffer.sv
// Circular sample history plus coefficient bank, read combinationally by tap index.
module fir_tap_buffer
    import fir_pkg::*;
#(
    parameter  int unsigned NTAPS = 4,
    localparam int unsigned PTR_W = $clog2(NTAPS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                smp_we,
    input  logic [SAMPLE_W-1:0] smp_data,
    input  logic                coef_we,
    input  logic [PTR_W-1:0]    coef_addr,
    input  logic [COEF_W-1:0]   coef_data,
    input  logic [PTR_W-1:0]    rd_tap,
    output logic [COEF_W-1:0]   coef_rd_c,
    output logic [SAMPLE_W-1:0] smp_rd_c
);

    logic [SAMPLE_W-1:0] smp_mem  [NTAPS];
    logic [COEF_W-1:0]   coef_mem [NTAPS];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    newest;
    logic [PTR_W-1:0]    rd_idx;

    // Storage writes; reset clears all history and coefficients.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            for (int unsigned i = 0; i < NTAPS; i++) begin
                smp_mem[i]  <= '0;
                coef_mem[i] <= '0;
            end
        end else begin
            if (smp_we) begin
                smp_mem[wr_ptr] <= smp_data;
                wr_ptr <= (wr_ptr == PTR_W'(NTAPS - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (coef_we && (32'(coef_addr) < NTAPS)) begin
                coef_mem[coef_addr] <= coef_data;
            end
        end
    end

    // Tap k reads the sample k positions older than the most recent write.
    always_comb begin
        newest = (wr_ptr == '0) ? PTR_W'(NTAPS - 1) : wr_ptr - PTR_W'(1);
        if (newest >= rd_tap) begin
            rd_idx = newest - rd_tap;
        end else begin
            rd_idx = PTR_W'(32'(newest) + NTAPS - 32'(rd_tap));
        end
    end

    assign smp_rd_c  = smp_mem[rd_idx];
    assign coef_rd_c = coef_mem[rd_tap];

endmodule

// File: rtl/fir_tap_sequencer.sv
// Time-multiplexes one external MAC across all FIR taps and saturates each result.
module fir_tap_sequencer
    import fir_pkg::*;
#(
    parameter  int unsigned NTAPS     = 4,
    parameter  int unsigned MAC_LAT   = 2,
    parameter  int unsigned OUT_SHIFT = 0,
    localparam int unsigned TAP_W     = $clog2(NTAPS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample_in,
    output logic                sample_ready,
    input  logic                coef_we,
    input  logic [TAP_W-1:0]    coef_addr,
    input  logic [COEF_W-1:0]   coef_data,
    output logic                coef_err,
    output logic [COEF_W-1:0]   mac_a,
    output logic [SAMPLE_W-1:0] mac_b,
    output logic                mac_issue,
    output logic                mac_load,
    input  logic [ACC_W-1:0]    mac_result,
    output logic [15:0]         y_out,
    output logic                y_valid
);

    localparam int unsigned CNT_W = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);

    fir_state_t              state;
    logic [TAP_W-1:0]        tap;
    logic [CNT_W-1:0]        drain_cnt;
    logic                    accept_c;
    logic                    coef_wr_c;
    logic [COEF_W-1:0]       coef_rd_c;
    logic [SAMPLE_W-1:0]     smp_rd_c;
    logic [COEF_W-1:0]       coef0_c;
    logic signed [ACC_W-1:0] acc_shifted_c;

    assign accept_c  = (state == IDLE) && sample_ready && sample_valid;
    assign coef_wr_c = coef_we && (state == IDLE);
    // A coefficient written on the accept edge must already reach tap 0.
    assign coef0_c   = (coef_wr_c && (coef_addr == '0)) ? coef_data : coef_rd_c;
    assign acc_shifted_c = $signed(mac_result) >>> OUT_SHIFT;

    fir_tap_buffer #(
        .NTAPS (NTAPS)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .smp_we    (accept_c),
        .smp_data  (sample_in),
        .coef_we   (coef_wr_c),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .rd_tap    (tap),
        .coef_rd_c (coef_rd_c),
        .smp_rd_c  (smp_rd_c)
    );

    // Sequencer: accept, issue one tap per cycle, wait out MAC latency, capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            tap          <= '0;
            drain_cnt    <= '0;
            sample_ready <= 1'b0;
            coef_err     <= 1'b0;
            mac_a        <= '0;
            mac_b        <= '0;
            mac_issue    <= 1'b0;
            mac_load     <= 1'b0;
            y_out        <= '0;
            y_valid      <= 1'b0;
        end else begin
            y_valid   <= 1'b0;
            mac_issue <= 1'b0;
            mac_load  <= 1'b0;
            coef_err  <= coef_we && (state != IDLE);
            case (state)
                IDLE: begin
                    sample_ready <= 1'b1;
                    if (accept_c) begin
                        sample_ready <= 1'b0;
                        mac_issue    <= 1'b1;
                        mac_load     <= 1'b1;
                        mac_a        <= coef0_c;
                        mac_b        <= sample_in;
                        tap          <= TAP_W'(1);
                        state        <= RUN;
                    end
                end
                RUN: begin
                    mac_issue <= 1'b1;
                    mac_a     <= coef_rd_c;
                    mac_b     <= smp_rd_c;
                    if (tap == TAP_W'(NTAPS - 1)) begin
                        tap       <= '0;
                        drain_cnt <= CNT_W'(MAC_LAT);
                        state     <= DRAIN;
                    end else begin
                        tap <= tap + TAP_W'(1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        y_out        <= sat16(acc_shifted_c);
                        y_valid      <= 1'b1;
                        sample_ready <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        drain_cnt <= drain_cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
